// File: rtl/csr_mon_pkg.sv
// csr_mon_pkg: shared definitions for the CSR debug-monitor controller.
//   - csr_op_e   : command op encodings (read / write / set bits / clear bits)
//   - state_e    : controller FSM state encodings
//   - MON_AW     : monitor CSR address width
//   - rmw_data() : value written to the CSR for a given op
package csr_mon_pkg;

  localparam int MON_AW = 12;
  localparam int MON_DW = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLR   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_STOP = 3'd1,
    S_READ      = 3'd2,
    S_WRITE     = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  // Data driven onto the write port: plain write passes the command data,
  // set/clear combine the old CSR value with the mask.
  function automatic logic [MON_DW-1:0] rmw_data(input csr_op_e op,
                                                 input logic [MON_DW-1:0] old,
                                                 input logic [MON_DW-1:0] mask);
    case (op)
      OP_SET:  rmw_data = old | mask;
      OP_CLR:  rmw_data = old & ~mask;
      default: rmw_data = mask;
    endcase
  endfunction

endpackage

// File: rtl/csr_mon_ctrl_if.sv
// csr_mon_ctrl_if: command/response handshake between the debug front end
// (master) and csr_mon_ctrl (slave).
//   cmd_valid/cmd_ready, cmd_op[1:0], cmd_adr[11:0], cmd_wdata[31:0]
//   rsp_valid/rsp_ready, rsp_data[31:0], rsp_err
interface csr_mon_ctrl_if;
  import csr_mon_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [MON_AW-1:0] cmd_adr;
  logic [MON_DW-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MON_DW-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/csr_mon_ctrl.sv
// csr_mon_ctrl: executes debug-monitor CSR commands (read / write / set /
// clear) against the CSR array once the CPU is halted.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   bus (slave)         - command/response handshake (csr_mon_ctrl_if)
//   cpu_stopped         - CPU halted with no CSR instruction in EX
//   csr_radr_en_mon/csr_radr_mon      - one-cycle monitor read request
//   csr_rdata_mon                     - combinational read data from the array
//   csr_we_mon/csr_wadr_mon/csr_wdata_mon - one-cycle monitor write strobe
// Parameter WAIT_MAX (>=1): cycles to wait for cpu_stopped before aborting.
// Build option: define CSR_MON_RMW_EN to enable set/clear read-modify-write;
// without it set/clear return an error immediately with no CSR access.
module csr_mon_ctrl
  import csr_mon_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  csr_mon_ctrl_if.slave     bus,
  input  logic              cpu_stopped,
  output logic              csr_radr_en_mon,
  output logic [MON_AW-1:0] csr_radr_mon,
  output logic              csr_we_mon,
  output logic [MON_AW-1:0] csr_wadr_mon,
  output logic [MON_DW-1:0] csr_wdata_mon,
  input  logic [MON_DW-1:0] csr_rdata_mon
);

  // Wait counter is at least 8 bits, wider only if WAIT_MAX needs it.
  localparam int CW = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;

  state_e            state;
  csr_op_e           op_q;
  logic [MON_AW-1:0] adr_q;
  logic [MON_DW-1:0] wdata_q;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      op_q            <= OP_READ;
      adr_q           <= '0;
      wdata_q         <= '0;
      cnt             <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_data    <= '0;
      csr_radr_en_mon <= 1'b0;
      csr_radr_mon    <= '0;
      csr_we_mon      <= 1'b0;
      csr_wadr_mon    <= '0;
      csr_wdata_mon   <= '0;
    end else begin
      // Strobes and their address/data are single-cycle; only the
      // transition into READ/WRITE below raises them.
      csr_radr_en_mon <= 1'b0;
      csr_radr_mon    <= '0;
      csr_we_mon      <= 1'b0;
      csr_wadr_mon    <= '0;
      csr_wdata_mon   <= '0;

      case (state)
        S_IDLE: begin
          // cmd_ready is high exactly while in IDLE, so cmd_valid alone
          // means a completed handshake here.
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            op_q          <= csr_op_e'(bus.cmd_op);
            adr_q         <= bus.cmd_adr;
            wdata_q       <= bus.cmd_wdata;
            cnt           <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
`ifdef CSR_MON_RMW_EN
            state <= S_WAIT_STOP;
`else
            if (bus.cmd_op[1]) begin
              // set/clear unsupported in this build
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else begin
              state <= S_WAIT_STOP;
            end
`endif
          end
        end

        S_WAIT_STOP: begin
          if (cpu_stopped) begin
            if (op_q == OP_WRITE) begin
              state         <= S_WRITE;
              csr_we_mon    <= 1'b1;
              csr_wadr_mon  <= adr_q;
              csr_wdata_mon <= wdata_q;
            end else begin
              state           <= S_READ;
              csr_radr_en_mon <= 1'b1;
              csr_radr_mon    <= adr_q;
            end
          end else if (cnt == CW'(WAIT_MAX - 1)) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_READ: begin
          // Old value is returned for read/set/clear; for set/clear it also
          // seeds the write data in the very next cycle.
          bus.rsp_data <= csr_rdata_mon;
          if (op_q == OP_READ) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            state         <= S_WRITE;
            csr_we_mon    <= 1'b1;
            csr_wadr_mon  <= adr_q;
            csr_wdata_mon <= rmw_data(op_q, csr_rdata_mon, wdata_q);
          end
        end

        S_WRITE: begin
          state         <= S_RESP;
          bus.rsp_valid <= 1'b1;
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_mon_ctrl.md
CSR_MON_CTRL -- requirements
Module: csr_mon_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255: maximum cycles to wait for CPU halt before the command aborts with an error.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1, command request from the debug front end.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted on cmd_valid&cmd_ready.
REQ-006 SHALL have port cmd_op, input, 2, operation: 00 read, 01 write, 10 set bits, 11 clear bits.
REQ-007 SHALL have port cmd_adr, input, 12, target CSR address.
REQ-008 SHALL have port cmd_wdata, input, 32, write data or bit mask.
REQ-009 SHALL have port cpu_stopped, input, 1, CPU is halted and no CSR instruction is in EX.
REQ-010 SHALL have port csr_radr_en_mon, output, 1, monitor read address enable to the CSR array.
REQ-011 SHALL have port csr_radr_mon, output, 12, monitor read address.
REQ-012 SHALL have port csr_we_mon, output, 1, monitor write strobe.
REQ-013 SHALL have port csr_wadr_mon, output, 12, monitor write address.
REQ-014 SHALL have port csr_wdata_mon, output, 32, monitor write data.
REQ-015 SHALL have port csr_rdata_mon, input, 32, combinational read data returned by the CSR array.
REQ-016 SHALL have port rsp_valid, output, 1, response available; held until rsp_ready.
REQ-017 SHALL have port rsp_ready, input, 1, response consumed.
REQ-018 SHALL have port rsp_data, output, 32, CSR value before the operation: old value for read/set/clear, 0 for plain write.
REQ-019 SHALL have port rsp_err, output, 1, high when the command was aborted by timeout or is an unsupported op.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_STOP, READ, WRITE, RESP.
REQ-021 SHALL assert cmd_ready only in IDLE; on accept SHALL latch op/adr/wdata and enter WAIT_STOP.
REQ-022 In WAIT_STOP, SHALL go to READ (read/set/clear) or WRITE (write) on the first cycle cpu_stopped=1; otherwise SHALL increment an 8-bit-min wait counter, and on reaching WAIT_MAX SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-023 READ SHALL last exactly one cycle: csr_radr_en_mon=1, csr_radr_mon=latched adr, capture csr_rdata_mon at the clock edge.
REQ-024 WRITE SHALL last exactly one cycle: csr_we_mon=1, csr_wadr_mon=latched adr, csr_wdata_mon = wdata (write), old|mask (set), old&~mask (clear).
REQ-025 From READ, SHALL go to RESP for a read and to WRITE for set/clear; csr_radr_en_mon and csr_we_mon SHALL never be high in the same cycle.
REQ-026 SHALL leave RESP to IDLE on rsp_valid&rsp_ready; rsp_data/rsp_err SHALL stay stable while rsp_valid=1.
REQ-027 If cpu_stopped drops in READ or WRITE, the access SHALL still complete (single-cycle, not retried).
REQ-028 Latency with cpu_stopped=1 and rsp_ready=1: read 3 cycles accept-to-rsp_valid, write 3, set/clear 4.
REQ-029 Strobes and address/data outputs SHALL be 0 outside their state.

Reset
REQ-030 rst SHALL force IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_data=0, all mon outputs 0; cmd_ready=1 in the first cycle after reset.
REQ-031 rst mid-operation SHALL abort without issuing a pending write strobe.

Configuration
REQ-032 Macro CSR_MON_RMW_EN: when defined, set/clear perform read-modify-write per REQ-024; when undefined, set/clear go IDLE->RESP without any CSR access and return rsp_err=1, rsp_data=0.

Structure
REQ-033 A shared package csr_mon_pkg SHALL hold op encodings, FSM state encodings, and the monitor address width (12).
REQ-034 SHALL be a single module; no sub-module.

Verification
REQ-035 Read 0x301 with cpu_stopped=1 -> one csr_radr_en_mon pulse at adr 0x301, rsp_data=0x4000_0100, rsp_err=0.
REQ-036 Write 0x305 data 0x0000_1000, then read 0x305 -> exactly one csr_we_mon pulse, then rsp_data=0x0000_1000.
REQ-037 mstatus=0x0000_0008, set mask 0x80 -> read then write of 0x0000_0088, rsp_data=0x0000_0008; clear mask 0x08 -> written 0x0000_0080.
REQ-038 cpu_stopped held 0, WAIT_MAX=4 -> no strobe issued, rsp_err=1 after 4 wait cycles; next command accepted.
REQ-039 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout.
REQ-040 Without CSR_MON_RMW_EN, set op -> no strobes, rsp_err=1; rst asserted in WAIT_STOP -> no csr_we_mon pulse, cmd_ready=1 in the first cycle after reset.
